// File: rtl/regfile_rmw_arbiter_pkg.sv
// Shared encodings for the register-file read-modify-write arbiter:
// op codes, FSM state type and default widths.
package rf_arb_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 1;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_ADD   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/regfile_rmw_arbiter_if.sv
// Requester and register-file signals of the RMW arbiter; slave = arbiter side,
// master = requesters plus register file.
interface regfile_rmw_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              req0_valid;
    logic              req0_op;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req0_done;
    logic [DATA_W-1:0] req0_result;

    logic              req1_valid;
    logic              req1_op;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              req1_done;
    logic [DATA_W-1:0] req1_result;

    logic [ADDR_W-1:0] rf_read_register;
    logic [DATA_W-1:0] rf_read_data;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_register;
    logic [DATA_W-1:0] rf_write_data;

    logic              busy;

    modport slave (
        input  req0_valid, req0_op, req0_addr, req0_data,
        output req0_ready, req0_done, req0_result,
        input  req1_valid, req1_op, req1_addr, req1_data,
        output req1_ready, req1_done, req1_result,
        output rf_read_register,
        input  rf_read_data,
        output rf_write_enable, rf_write_register, rf_write_data,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_addr, req0_data,
        input  req0_ready, req0_done, req0_result,
        output req1_valid, req1_op, req1_addr, req1_data,
        input  req1_ready, req1_done, req1_result,
        input  rf_read_register,
        output rf_read_data,
        input  rf_write_enable, rf_write_register, rf_write_data,
        input  busy
    );

endinterface

// File: rtl/regfile_rmw_arbiter_rr.sv
// Two-way round-robin grant with a last-grant pointer; reset favours requester 0.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index that wins when both requesters are valid.
    logic prio_q;
    logic prio_d;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_rmw_arbiter.sv
// Two-requester read-modify-write arbiter in front of a register file.
// Define RMW_ARB_SATURATE_EN to make ADD saturate at all-ones instead of wrapping.
module regfile_rmw_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_rmw_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        grant;
    logic              accept;
    logic [DATA_W:0]   sum_wide;
    logic [DATA_W-1:0] add_value;

    // Grants are only offered in IDLE and never while reset is high.
    assign accept = (state_q == IDLE) && !reset && (grant != 2'b00);

    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        if (accept) begin
            owner_d = grant[1];
            op_d    = grant[1] ? bus.req1_op   : bus.req0_op;
            addr_d  = grant[1] ? bus.req1_addr : bus.req0_addr;
            data_d  = grant[1] ? bus.req1_data : bus.req0_data;
        end
        if (state_q == READ) begin
            rdata_d = bus.rf_read_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q    <= OP_WRITE;
            addr_q  <= '0;
            data_q  <= '0;
            owner_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        sum_wide = {1'b0, rdata_q} + {1'b0, data_q};
`ifdef RMW_ARB_SATURATE_EN
        add_value = sum_wide[DATA_W] ? '1 : sum_wide[DATA_W-1:0];
`else
        add_value = sum_wide[DATA_W-1:0];
`endif
    end

    // Outputs are forced low for the whole reset cycle, including mid-operation.
    always_comb begin
        bus.req0_ready        = 1'b0;
        bus.req1_ready        = 1'b0;
        bus.req0_done         = 1'b0;
        bus.req1_done         = 1'b0;
        bus.req0_result       = '0;
        bus.req1_result       = '0;
        bus.rf_read_register  = '0;
        bus.rf_write_enable   = 1'b0;
        bus.rf_write_register = '0;
        bus.rf_write_data     = '0;
        bus.busy              = 1'b0;
        if (!reset) begin
            bus.busy = (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    bus.req0_ready = grant[0];
                    bus.req1_ready = grant[1];
                end
                READ: begin
                    bus.rf_read_register = addr_q;
                end
                WRITE: begin
                    bus.rf_write_enable   = 1'b1;
                    bus.rf_write_register = addr_q;
                    bus.rf_write_data     = (op_q == OP_ADD) ? add_value : data_q;
                end
                DONE: begin
                    if (owner_q) begin
                        bus.req1_done   = 1'b1;
                        bus.req1_result = rdata_q;
                    end else begin
                        bus.req0_done   = 1'b1;
                        bus.req0_result = rdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
